mem_bus_arbiter: RTL and testbench

- Two-master to one-slave arbiter for the shared memory port.
- Lets the instruction fetch bus (read-only) and the data bus (read/write) share a single-port memory or peripheral slave.
- Sits between the core's ibus/dbus masters and the slave bus.
- Round-robin on contention, one outstanding transfer at a time, completion signalled by bdone.

---
 rtl/bus_pkg.sv | 12 +
 rtl/mem_bus_arbiter_rr_arb2.sv | 23 ++
 rtl/mem_bus_arbiter.sv | 142 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared bus types for the ibus/dbus to slave-port arbiter.
package bus_pkg;

  typedef enum logic {READ = 1'b0, WRITE = 1'b1} ttype_t;

  typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} tsize_t;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2} arb_state_t;

  typedef enum logic {M_I = 1'b0, M_D = 1'b1} master_id_t;

endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: on a tie the master that did not
// win last time is chosen.
module rr_arb2
  import bus_pkg::*;
(
  input  logic       i_breq,
  input  logic       d_breq,
  input  master_id_t last_grant,
  output master_id_t grant,
  output logic       grant_valid
);

  always_comb begin
    grant       = M_I;
    grant_valid = i_breq | d_breq;
    if (i_breq && d_breq) begin
      grant = (last_grant == M_I) ? M_D : M_I;
    end else if (d_breq) begin
      grant = M_D;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master (ibus read-only, dbus read/write) to one-slave arbiter, one
// outstanding transfer. Optional slave watchdog: define ARB_TIMEOUT_EN.
module mem_bus_arbiter
  import bus_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_breq,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_bdone,
  output logic          i_berror,
  input  logic          d_breq,
  input  ttype_t        d_ttype,
  input  tsize_t        d_tsize,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_bdone,
  output logic          d_berror,
  output logic          s_breq,
  output ttype_t        s_ttype,
  output tsize_t        s_tsize,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_bdone
);

  arb_state_t state, state_next;
  master_id_t last_grant, last_grant_next;
  master_id_t grant;
  logic       grant_valid;
  logic       done;
  logic       timeout;

  rr_arb2 u_rr_arb2 (
    .i_breq     (i_breq),
    .d_breq     (d_breq),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_valid(grant_valid)
  );

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wd_cnt;

  // Counts BUSY cycles without a slave response; zero whenever not waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (state == IDLE || done) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + CW'(1);
    end
  end

  // A real s_bdone in the final cycle wins over the watchdog.
  assign timeout = (state != IDLE) && !s_bdone && (wd_cnt == CW'(TIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  assign done = (state != IDLE) && (s_bdone || timeout);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= M_D;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
    end
  end

  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          state_next = (grant == M_I) ? BUSY_I : BUSY_D;
        end
      end
      BUSY_I: begin
        if (done) begin
          state_next      = IDLE;
          last_grant_next = M_I;
        end
      end
      BUSY_D: begin
        if (done) begin
          state_next      = IDLE;
          last_grant_next = M_D;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Slave-side mux and master-side returns; only the granted master sees activity.
  always_comb begin
    s_breq   = 1'b0;
    s_ttype  = READ;
    s_tsize  = WORD;
    s_addr   = '0;
    s_wdata  = '0;
    i_rdata  = '0;
    i_bdone  = 1'b0;
    i_berror = 1'b0;
    d_rdata  = '0;
    d_bdone  = 1'b0;
    d_berror = 1'b0;
    case (state)
      BUSY_I: begin
        s_breq   = 1'b1;
        s_addr   = i_addr;
        i_bdone  = done;
        i_berror = timeout;
        i_rdata  = s_bdone ? s_rdata : '0;
      end
      BUSY_D: begin
        s_breq   = 1'b1;
        s_ttype  = d_ttype;
        s_tsize  = d_tsize;
        s_addr   = d_addr;
        s_wdata  = d_wdata;
        d_bdone  = done;
        d_berror = timeout;
        d_rdata  = s_bdone ? s_rdata : '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboarded bench for mem_bus_arbiter: master drivers, a latency-controlled
// slave, and a completion monitor checking against an expected queue.
module tb_mem_bus_arbiter;
  import bus_pkg::*;

  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;
  localparam int B_ERR   = 0;
  localparam int WD_LO   = 1;
  localparam int AD_LO   = 1 + DW;
  localparam int SZ_LO   = 1 + DW + AW;
  localparam int TT      = 3 + DW + AW;
  localparam int MS      = 4 + DW + AW;
  localparam int EW      = 5 + DW + AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_breq;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_bdone, i_berror;
  logic          d_breq;
  ttype_t        d_ttype;
  tsize_t        d_tsize;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_bdone, d_berror;
  logic          s_breq;
  ttype_t        s_ttype;
  tsize_t        s_tsize;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic [DW-1:0] s_rdata;
  logic          s_bdone;

  int vectors = 0;
  int errors  = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] i_req_q[$];
  logic [EW-1:0] d_req_q[$];

  bit i_busy = 0, i_done_seen = 0;
  bit d_busy = 0, d_done_seen = 0;
  int slave_lat  = 0;
  bit slave_mute = 0;
  int busy_cyc   = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_breq(i_breq), .i_addr(i_addr), .i_rdata(i_rdata),
    .i_bdone(i_bdone), .i_berror(i_berror),
    .d_breq(d_breq), .d_ttype(d_ttype), .d_tsize(d_tsize),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_rdata(d_rdata),
    .d_bdone(d_bdone), .d_berror(d_berror),
    .s_breq(s_breq), .s_ttype(s_ttype), .s_tsize(s_tsize),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata), .s_bdone(s_bdone)
  );

  function automatic logic [EW-1:0] pack(input logic m, input logic tt, input logic [1:0] ts,
                                         input logic [AW-1:0] a, input logic [DW-1:0] w,
                                         input logic be);
    return {m, tt, ts, a, w, be};
  endfunction

  // Master drivers: hold a request until bdone, then drop or present the next one.
  initial begin
    logic [EW-1:0] cur;
    i_breq = 1'b0;
    i_addr = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        i_busy = 0; i_breq = 1'b0; i_done_seen = 0;
      end else if (i_busy && i_done_seen) begin
        i_busy = 0; i_breq = 1'b0; i_done_seen = 0;
      end
      if (rst_n && !i_busy && i_req_q.size() > 0) begin
        cur    = i_req_q.pop_front();
        i_addr = cur[AD_LO +: AW];
        i_breq = 1'b1;
        i_busy = 1;
      end
    end
  end

  initial begin
    logic [EW-1:0] cur;
    d_breq  = 1'b0;
    d_ttype = READ;
    d_tsize = WORD;
    d_addr  = '0;
    d_wdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        d_busy = 0; d_breq = 1'b0; d_done_seen = 0;
      end else if (d_busy && d_done_seen) begin
        d_busy = 0; d_breq = 1'b0; d_done_seen = 0;
      end
      if (rst_n && !d_busy && d_req_q.size() > 0) begin
        cur     = d_req_q.pop_front();
        d_ttype = ttype_t'(cur[TT]);
        d_tsize = tsize_t'(cur[SZ_LO +: 2]);
        d_addr  = cur[AD_LO +: AW];
        d_wdata = cur[WD_LO +: DW];
        d_breq  = 1'b1;
        d_busy  = 1;
      end
    end
  end

  // Slave: answers slave_lat cycles after the first BUSY cycle unless muted.
  initial begin
    s_bdone = 1'b0;
    s_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (s_breq) begin
        if (busy_cyc == 0) s_rdata = $urandom;
        s_bdone = !slave_mute && (busy_cyc == slave_lat);
        busy_cyc++;
      end else begin
        busy_cyc = 0;
        s_bdone  = 1'b0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic [EW-1:0] e;
    logic          got_m, got_be;
    logic [DW-1:0] got_rd, exp_rd;
    logic          i_prev_req, i_prev_done, d_prev_req, d_prev_done;
    i_prev_req = 0; i_prev_done = 0; d_prev_req = 0; d_prev_done = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        i_prev_req = 0; i_prev_done = 0; d_prev_req = 0; d_prev_done = 0;
      end else begin
        vectors++;
        if (i_bdone && d_bdone) begin
          errors++; $display("FAIL overlap: i_bdone=%b d_bdone=%b, required not both", i_bdone, d_bdone);
        end
        vectors++;
        if (!i_bdone && (i_rdata !== '0 || i_berror !== 1'b0)) begin
          errors++; $display("FAIL i_quiet: i_rdata=%h i_berror=%b, required 0", i_rdata, i_berror);
        end
        vectors++;
        if (!d_bdone && (d_rdata !== '0 || d_berror !== 1'b0)) begin
          errors++; $display("FAIL d_quiet: d_rdata=%h d_berror=%b, required 0", d_rdata, d_berror);
        end
        if ((i_prev_req && !i_prev_done && !i_breq) || (d_prev_req && !d_prev_done && !d_breq)) begin
          errors++; $display("FAIL protocol: breq dropped before bdone");
        end
        i_prev_req = i_breq; i_prev_done = i_bdone;
        d_prev_req = d_breq; d_prev_done = d_bdone;
        if (i_bdone || d_bdone) begin
          if (i_bdone) i_done_seen = 1;
          if (d_bdone) d_done_seen = 1;
          vectors++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL unexpected_done: i_bdone=%b d_bdone=%b, none expected", i_bdone, d_bdone);
          end else begin
            e      = exp_q.pop_front();
            got_m  = d_bdone;
            got_be = d_bdone ? d_berror : i_berror;
            got_rd = d_bdone ? d_rdata : i_rdata;
            exp_rd = e[B_ERR] ? '0 : s_rdata;
            if (got_m !== e[MS]) begin
              errors++; $display("FAIL grant_order: master=%0d, required %0d", got_m, e[MS]);
            end
            vectors++;
            if (s_ttype !== e[TT] || s_tsize !== e[SZ_LO +: 2]) begin
              errors++; $display("FAIL slave_type: ttype=%0d tsize=%0d, required %0d %0d",
                                 s_ttype, s_tsize, e[TT], e[SZ_LO +: 2]);
            end
            vectors++;
            if (s_addr !== e[AD_LO +: AW] || s_wdata !== e[WD_LO +: DW]) begin
              errors++; $display("FAIL slave_addr_data: addr=%h wdata=%h, required %h %h",
                                 s_addr, s_wdata, e[AD_LO +: AW], e[WD_LO +: DW]);
            end
            vectors++;
            if (got_be !== e[B_ERR] || got_rd !== exp_rd) begin
              errors++; $display("FAIL completion: berror=%b rdata=%h, required %b %h",
                                 got_be, got_rd, e[B_ERR], exp_rd);
            end
          end
        end
      end
    end
  end

  task automatic drain(input int budget, output bit ok);
    ok = 0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && i_req_q.size() == 0 && d_req_q.size() == 0 && !i_busy && !d_busy) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (s_breq !== 1'b0 || s_ttype !== READ || s_tsize !== WORD || s_addr !== '0 || s_wdata !== '0) begin
      errors++; $display("FAIL reset_slave: breq=%b ttype=%0d tsize=%0d addr=%h wdata=%h, required 0 READ WORD 0 0",
                         s_breq, s_ttype, s_tsize, s_addr, s_wdata);
    end
    vectors++;
    if (i_bdone !== 0 || d_bdone !== 0 || i_berror !== 0 || d_berror !== 0 || i_rdata !== '0 || d_rdata !== '0) begin
      errors++; $display("FAIL reset_master: i_bdone=%b d_bdone=%b i_rdata=%h d_rdata=%h, required 0",
                         i_bdone, d_bdone, i_rdata, d_rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ibus_read();
    int n;
    bit ok;
    slave_lat = 0;
    exp_q.push_back(pack(M_I, READ, WORD, 32'h100, '0, 1'b0));
    i_req_q.push_back(pack(M_I, READ, WORD, 32'h100, '0, 1'b0));
    n = 0;
    while (i_breq !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    vectors++;
    if (s_breq !== 1'b0) begin
      errors++; $display("FAIL ird_cycle0: s_breq=%b, required 0", s_breq);
    end
    @(negedge clk);
    vectors++;
    if (s_breq !== 1'b1 || i_bdone !== 1'b1 || d_bdone !== 1'b0 || i_rdata !== s_rdata) begin
      errors++; $display("FAIL ird_cycle1: s_breq=%b i_bdone=%b d_bdone=%b i_rdata=%h, required 1 1 0 %h",
                         s_breq, i_bdone, d_bdone, i_rdata, s_rdata);
    end
    drain(20, ok);
    vectors++;
    if (!ok) begin errors++; $display("FAIL ird_drain: timed out, required completion"); end
  endtask

  task automatic test_dbus_write();
    int pulses;
    bit ok;
    exp_q.push_back(pack(M_D, WRITE, HALF, 32'h204, 32'hBEEF, 1'b0));
    d_req_q.push_back(pack(M_D, WRITE, HALF, 32'h204, 32'hBEEF, 1'b0));
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (d_bdone) pulses++;
    end
    vectors++;
    if (pulses !== 1) begin
      errors++; $display("FAIL dwr_pulses: d_bdone pulses=%0d, required 1", pulses);
    end
    drain(20, ok);
    vectors++;
    if (!ok) begin errors++; $display("FAIL dwr_drain: timed out, required completion"); end
  endtask

  task automatic test_contention();
    bit ok;
    logic [EW-1:0] ireq, dreq;
    pulse_reset();
    slave_lat = 0;
    for (int k = 0; k < 4; k++) begin
      ireq = pack(M_I, READ, WORD, 32'h1000 + 32'(k * 4), '0, 1'b0);
      dreq = pack(M_D, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
                  32'h2000 + 32'(k * 4), $urandom, 1'b0);
      i_req_q.push_back(ireq);
      d_req_q.push_back(dreq);
      exp_q.push_back(ireq);
      exp_q.push_back(dreq);
    end
    drain(100, ok);
    vectors++;
    if (!ok) begin errors++; $display("FAIL contention_drain: %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int n;
    bit ok;
    slave_lat = 3;
    exp_q.push_back(pack(M_I, READ, WORD, 32'h300, '0, 1'b0));
    i_req_q.push_back(pack(M_I, READ, WORD, 32'h300, '0, 1'b0));
    n = 0;
    while (s_breq !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    vectors++;
    if (n >= 10) begin errors++; $display("FAIL wait_grant: s_breq=%b, required 1", s_breq); end
    exp_q.push_back(pack(M_D, READ, BYTE, 32'h404, 32'h55AA, 1'b0));
    d_req_q.push_back(pack(M_D, READ, BYTE, 32'h404, 32'h55AA, 1'b0));
    n = 0;
    while (!i_bdone && n < 10) begin
      @(negedge clk);
      n++;
      vectors++;
      if (s_addr !== 32'h300) begin
        errors++; $display("FAIL wait_hold: s_addr=%h, required 300", s_addr);
      end
    end
    slave_lat = 0;
    drain(30, ok);
    vectors++;
    if (!ok) begin errors++; $display("FAIL wait_drain: timed out, required completion"); end
  endtask

  task automatic test_reset_mid();
    int n;
    bit ok, seen;
    slave_mute = 1;
    d_req_q.push_back(pack(M_D, WRITE, WORD, 32'h500, 32'h1234, 1'b0));
    n = 0;
    while (s_breq !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    d_req_q.delete();
    #1;
    vectors++;
    if (s_breq !== 1'b0 || d_bdone !== 1'b0) begin
      errors++; $display("FAIL rst_mid: s_breq=%b d_bdone=%b, required 0 0", s_breq, d_bdone);
    end
    seen = 0;
    repeat (2) begin @(negedge clk); if (d_bdone) seen = 1; end
    vectors++;
    if (seen) begin errors++; $display("FAIL rst_no_done: d_bdone=1, required 0"); end
    rst_n = 1'b1;
    slave_mute = 0;
    i_req_q.push_back(pack(M_I, READ, WORD, 32'h700, '0, 1'b0));
    d_req_q.push_back(pack(M_D, READ, WORD, 32'h704, '0, 1'b0));
    exp_q.push_back(pack(M_I, READ, WORD, 32'h700, '0, 1'b0));
    exp_q.push_back(pack(M_D, READ, WORD, 32'h704, '0, 1'b0));
    drain(30, ok);
    vectors++;
    if (!ok) begin errors++; $display("FAIL rst_drain: timed out, required completion"); end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    bit ok;
    for (int pass = 0; pass < 2; pass++) begin
      slave_mute = (pass == 0);
      slave_lat  = TIMEOUT - 1;
      exp_q.push_back(pack(M_D, READ, WORD, 32'h600 + 32'(pass * 4), '0, 1'(pass == 0)));
      d_req_q.push_back(pack(M_D, READ, WORD, 32'h600 + 32'(pass * 4), '0, 1'b0));
      n = 0;
      while (s_breq !== 1'b1 && n < 10) begin @(negedge clk); n++; end
      n = 1;
      while (!d_bdone && n < 40) begin @(negedge clk); n++; end
      vectors++;
      if (n !== TIMEOUT) begin
        errors++; $display("FAIL timeout_cycles pass%0d: done in busy cycle %0d, required %0d", pass, n, TIMEOUT);
      end
      @(negedge clk);
      vectors++;
      if (s_breq !== 1'b0) begin
        errors++; $display("FAIL timeout_idle pass%0d: s_breq=%b, required 0", pass, s_breq);
      end
      drain(20, ok);
      vectors++;
      if (!ok) begin errors++; $display("FAIL timeout_drain: timed out, required completion"); end
    end
    slave_mute = 0;
    slave_lat  = 0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_ibus_read();
    test_dbus_write();
    test_contention();
    test_back_to_back();
    test_reset_mid();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
